// File: rtl/n64a_vdemux_ctrl.sv
// n64a_vdemux_ctrl: watches demux sync samples, measures lines per field and commits PAL/interlace mode.
// Optional macro VDEMUX_CTRL_AUTODEBLUR_EN enables automatic deblur selection for deblur_mode_i = 2'b10.
module n64a_vdemux_ctrl #(
    parameter int PAL_THRESH    = 288,
    parameter int STABLE_FIELDS = 4,
    parameter int LINE_MAX      = 1023
) (
    input  logic       VCLK,
    input  logic       RST,
    input  logic       vdata_valid_0,
    input  logic [3:0] vdata_sy_0,
    input  logic [1:0] deblur_mode_i,
    input  logic       n16bit_mode_i,
    output logic [2:0] demuxparams_o,
    output logic       locked_o,
    output logic       interlaced_o,
    output logic [9:0] lines_o
);
    localparam int SW = (STABLE_FIELDS > 1) ? $clog2(STABLE_FIELDS) : 1;
    localparam logic [SW-1:0] STABLE_TOP = SW'(STABLE_FIELDS - 1);
    localparam logic [9:0]    CNT_TOP    = 10'(LINE_MAX);
    localparam logic [9:0]    CNT_PRE    = 10'(LINE_MAX - 1);
    localparam logic [9:0]    PAL_LINES  = 10'(PAL_THRESH);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_MEASURE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t        state_reg;
    logic [3:0]    sy_prev_reg;
    logic [9:0]    cnt_reg;
    logic [SW-1:0] stable_reg;
    logic          hist_v_reg;
    logic          cand_v_reg;
    logic          cand_pal_reg;
    logic          cand_il_reg;
    logic          palmode_reg;
    logic          param_load_reg;

    logic          field_start;
    logic          line_tick;
    logic          timeout;
    logic          cand_pal;
    logic          cand_il;
    logic          cand_match;
    logic [SW-1:0] stable_next;
    logic          commit;
    logic          ndo_deblur;
    logic          sync_unused;

    // Only nVSYNC and nHSYNC edges matter; clamp and composite sync are carried along in sy_prev.
    assign sync_unused = ^{sy_prev_reg[2], sy_prev_reg[0]};

    assign field_start = vdata_valid_0 & sy_prev_reg[3] & ~vdata_sy_0[3];
    assign line_tick   = vdata_valid_0 & sy_prev_reg[1] & ~vdata_sy_0[1];
    // A tick that lands the counter on LINE_MAX is the timeout; a coincident field start overrides it.
    assign timeout     = line_tick & ~field_start & (cnt_reg >= CNT_PRE);

    always_comb begin
        cand_pal    = (cnt_reg >= PAL_LINES);
        cand_il     = (cnt_reg[0] != lines_o[0]);
        cand_match  = cand_v_reg && (cand_pal == cand_pal_reg) && (cand_il == cand_il_reg);
        stable_next = '0;
        if (cand_match)
            stable_next = (stable_reg == STABLE_TOP) ? stable_reg : stable_reg + 1'b1;
        commit = (stable_next == STABLE_TOP);
    end

    always_comb begin
        ndo_deblur = 1'b1;
        case (deblur_mode_i)
            2'b01:   ndo_deblur = 1'b0;
`ifdef VDEMUX_CTRL_AUTODEBLUR_EN
            2'b10:   ndo_deblur = ~(locked_o & ~interlaced_o);
`endif
            default: ndo_deblur = 1'b1;
        endcase
    end

    always_ff @(posedge VCLK) begin
        if (RST) begin
            state_reg      <= ST_UNLOCKED;
            sy_prev_reg    <= 4'hF;
            cnt_reg        <= '0;
            stable_reg     <= '0;
            hist_v_reg     <= 1'b0;
            cand_v_reg     <= 1'b0;
            cand_pal_reg   <= 1'b0;
            cand_il_reg    <= 1'b0;
            palmode_reg    <= 1'b0;
            param_load_reg <= 1'b0;
            locked_o       <= 1'b0;
            interlaced_o   <= 1'b0;
            lines_o        <= '0;
            demuxparams_o  <= 3'b010;
        end else begin
            param_load_reg <= field_start;
            if (vdata_valid_0)
                sy_prev_reg <= vdata_sy_0;

            if (field_start)
                cnt_reg <= '0;
            else if (line_tick && cnt_reg != CNT_TOP)
                cnt_reg <= cnt_reg + 10'd1;

            if (timeout) begin
                state_reg    <= ST_UNLOCKED;
                locked_o     <= 1'b0;
                interlaced_o <= 1'b0;
            end else if (field_start) begin
                case (state_reg)
                    ST_UNLOCKED: begin
                        // The field in progress is partial; start measuring from this boundary.
                        state_reg  <= ST_MEASURE;
                        stable_reg <= '0;
                        hist_v_reg <= 1'b0;
                        cand_v_reg <= 1'b0;
                    end
                    default: begin
                        lines_o <= cnt_reg;
                        if (!hist_v_reg) begin
                            hist_v_reg <= 1'b1;
                        end else begin
                            stable_reg   <= stable_next;
                            cand_pal_reg <= cand_pal;
                            cand_il_reg  <= cand_il;
                            cand_v_reg   <= 1'b1;
                            if (commit) begin
                                palmode_reg  <= cand_pal;
                                interlaced_o <= cand_il;
                                locked_o     <= 1'b1;
                                state_reg    <= ST_LOCKED;
                            end
                        end
                    end
                endcase
            end

            // The demux only sees new parameters right after a field boundary, or freely while unlocked.
            if (param_load_reg || state_reg == ST_UNLOCKED)
                demuxparams_o <= {palmode_reg, ndo_deblur, n16bit_mode_i};
        end
    end
endmodule

// File: doc/n64a_vdemux_ctrl.md
# n64a_vdemux_ctrl

- Supervises and configures the N64 video demultiplexer.
- Watches the sync nibble the demux captures each pixel slot and counts lines per field.
- Derives PAL/NTSC and progressive/interlaced mode with field-level hysteresis.
- Drives the demux parameter word `{palmode, ndo_deblur, n16bit_mode}`.
- Parameter changes take effect only at field boundaries, so the demux never sees a mode switch mid-field.

## Interface

Parameters:
- `PAL_THRESH`, default 288: lines per field at or above this value mean PAL.
- `STABLE_FIELDS`, default 4: number of consecutive agreeing field candidates needed before a mode is committed.
- `LINE_MAX`, default 1023: saturation value of the line counter; reaching it is a timeout.

Ports (name, direction, width, meaning):
- `VCLK` in 1: video clock; the only clock.
- `RST` in 1: synchronous, active-high reset.
- `vdata_valid_0` in 1: strobe marking that the sync sample `vdata_sy_0` is new (one per pixel slot).
- `vdata_sy_0` in 4: sync sample `{nVSYNC, nCLAMP, nHSYNC, nCSYNC}`.
- `deblur_mode_i` in 2: deblur selection. 00 = off, 01 = forced on, 10 = auto, 11 = treated as off.
- `n16bit_mode_i` in 1: requested colour depth, passed through to the demux.
- `demuxparams_o` out 3: `{palmode, ndo_deblur, n16bit_mode}` to the demux.
- `locked_o` out 1: mode is committed and sync is present.
- `interlaced_o` out 1: committed interlace flag.
- `lines_o` out 10: line count of the last complete field.

## Operation

- **Edge detection.** On each `vdata_valid_0`, the block registers `vdata_sy_0` as `sy_prev`.
  - Field start: `sy_prev[3]=1` and `vdata_sy_0[3]=0`.
  - Line tick: `sy_prev[1]=1` and `vdata_sy_0[1]=0`.
  - Cycles without the strobe are ignored.
- **Line counter `cnt`** (10 bits):
  - Cleared at field start.
  - Increments on each line tick and saturates at `LINE_MAX`.
  - When it reaches `LINE_MAX`, the block times out and goes to UNLOCKED.
- **State machine:**
  - UNLOCKED → MEASURE on a field start. This clears `cnt`, `stable`, `hist_v` and `cand_v`. The partial field is discarded.
  - MEASURE, field start with `hist_v=0`: `lines_o <= cnt`, `hist_v <= 1`.
  - MEASURE, field start with `hist_v=1`: form the candidate.
    - `cand_pal = (cnt >= PAL_THRESH)`.
    - `cand_il = (cnt[0] != lines_o[0])`.
    - If `cand_v` is set and the candidate equals the previous candidate, `stable` increments. Otherwise `stable` is cleared.
    - The candidate is stored, `cand_v <= 1`, and `lines_o <= cnt`.
    - When the updated `stable` reaches `STABLE_FIELDS-1`, commit `palmode` and `interlaced`, set `locked_o=1`, and go to LOCKED.
  - LOCKED, field start: the same candidate logic runs.
    - A differing candidate clears `stable`.
    - The committed mode changes only when `STABLE_FIELDS-1` consecutive agreements accumulate on the new candidate. `locked_o` stays 1 while this happens.
  - Timeout in any state: go to UNLOCKED, `locked_o <= 0`, `interlaced_o <= 0`. `palmode` keeps its last value.
- **`ndo_deblur`:**
  - mode 01 → 0.
  - mode 10 → 0 only if `locked_o` and not `interlaced_o`, else 1.
  - mode 00 or 11 → 1.
- **`demuxparams_o` update:**
  - Loaded from the computed values in the cycle after each field-start strobe.
  - In UNLOCKED, also loaded every cycle.
  - Never changes at any other time.
- **Counter widths:** `stable` is wide enough for `STABLE_FIELDS-1` and saturates there.

## Timing

- Reset values:
  - `demuxparams_o = 3'b010`.
  - `locked_o = 0`, `interlaced_o = 0`, `lines_o = 0`.
  - State UNLOCKED; `sy_prev = 4'hF`.
- Latency: a field start or line tick sampled on `vdata_valid_0` at edge N shows in the registers at edge N+1. Outputs depending on commit update at edge N+1.
- First lock requires field starts at 1 (enter MEASURE), 2 (history), then `STABLE_FIELDS` more. With defaults, `locked_o` rises one cycle after the 6th field start.
- Simultaneous field start and line tick on the same strobe: the field start wins, and `cnt` clears to 0 (the tick is not counted).
- Field start on the same strobe where `cnt` would saturate: the field start is processed and there is no timeout.
- `RST` asserted mid-field: all state returns to its reset values on the next edge. `demuxparams_o` goes to 3'b010 immediately, not at a field boundary.
- A change of `deblur_mode_i` or `n16bit_mode_i` while LOCKED appears at the next field start.

## Configuration

- Macro `VDEMUX_CTRL_AUTODEBLUR_EN`.
  - Defined: mode 10 selects deblur automatically as described above.
  - Undefined: mode 10 behaves as off (`ndo_deblur=1`). The interlace candidate and `interlaced_o` logic are still built.

## Test plan

- **NTSC 240p:** 8 fields of 263 lines, `deblur_mode_i=10`, `n16bit_mode_i=1` → after the 6th field start, `locked_o=1`, `interlaced_o=0`, `lines_o=263`, `demuxparams_o=3'b001`.
- **PAL 480i:** fields alternating 312/313, auto mode → after the 6th field start, `locked_o=1`, `interlaced_o=1`, `demuxparams_o=3'b11x`.
- **Glitch rejection:** locked NTSC 240p stream, one 300-line field inserted → `palmode` stays 0, `locked_o` stays 1, and `demuxparams_o` is unchanged at every field start.
- **Timeout:** locked stream, then nVSYNC held high for 1023 line ticks → `locked_o=0` one cycle after the 1023rd tick; `ndo_deblur=1` in auto mode.
- **Reset mid-MEASURE:** `RST` pulsed high for one cycle after 3 fields → the next edge shows `demuxparams_o=3'b010` and `lines_o=0`, and lock needs 6 new field starts.
- **Macro undefined:** NTSC 240p with `deblur_mode_i=10` → `demuxparams_o[1]=1` after lock. With `deblur_mode_i=01`, `demuxparams_o[1]=0`.
